// File: rtl/pc_pkg.sv
// pc_pkg: shared widths and reset value for the fetch-stage PC logic
package pc_pkg;
  localparam int PC_WIDTH = 64;
  localparam int INSTR_BYTES = 4;
  localparam int COND_W = 19;
  localparam int BR_W = 26;
  localparam logic [PC_WIDTH-1:0] RESET_PC = '0;
endpackage

// File: rtl/pc_branch_offset.sv
// pc_branch_offset: sign-extends the selected branch word offset and scales it to bytes
module pc_branch_offset #(
  parameter int W  = 64,
  parameter int CW = 19,
  parameter int BW = 26
) (
  input  logic [CW-1:0] cond_addr19,
  input  logic [BW-1:0] br_addr26,
  input  logic          uncond_br,
  output logic [W-1:0]  off_sh
);
  logic [W-1:0] w_cond;
  logic [W-1:0] w_br;
  assign w_cond = {{(W-CW){cond_addr19[CW-1]}}, cond_addr19};
  assign w_br   = {{(W-BW){br_addr26[BW-1]}}, br_addr26};
  assign off_sh = (uncond_br ? w_br : w_cond) << 2;
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: fetch-stage PC register with sequential/branch next-PC selection
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int                  P_PC_WIDTH = PC_WIDTH,
  parameter int                  P_COND_W   = COND_W,
  parameter int                  P_BR_W     = BR_W,
  parameter logic [P_PC_WIDTH-1:0] P_RESET_PC = RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_en,
  input  logic [P_COND_W-1:0]   cond_addr19,
  input  logic [P_BR_W-1:0]     br_addr26,
  input  logic                  uncond_br,
  input  logic                  br_taken,
  output logic [P_PC_WIDTH-1:0] pc,
  output logic [P_PC_WIDTH-1:0] next_pc
);
  logic [P_PC_WIDTH-1:0] r_pc;
  logic [P_PC_WIDTH-1:0] w_off;
  logic [P_PC_WIDTH-1:0] w_seq;
  logic [P_PC_WIDTH-1:0] w_tgt;
  pc_branch_offset #(.W(P_PC_WIDTH), .CW(P_COND_W), .BW(P_BR_W)) u_off (
    .cond_addr19(cond_addr19),
    .br_addr26  (br_addr26),
    .uncond_br  (uncond_br),
    .off_sh     (w_off)
  );
  assign w_seq   = r_pc + P_PC_WIDTH'(INSTR_BYTES);
  assign w_tgt   = r_pc + w_off;
  assign next_pc = br_taken ? w_tgt : w_seq;
  assign pc      = r_pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pc <= P_RESET_PC;
    else if (pc_en) r_pc <= next_pc;
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: scoreboard bench for pc_next_unit against an arithmetic reference model
module tb_pc_next_unit;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        pc_en = 0;
  logic [18:0] cond_addr19 = '0;
  logic [25:0] br_addr26 = '0;
  logic        uncond_br = 0;
  logic        br_taken = 0;
  logic [63:0] pc;
  logic [63:0] next_pc;
  typedef struct {logic [63:0] pc; logic [63:0] nx;} exp_t;
  exp_t        q[$];
  logic [63:0] m_pc = '0;
  int          n_pass = 0;
  int          n_tot = 0;
  pc_next_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_en(pc_en), .cond_addr19(cond_addr19),
    .br_addr26(br_addr26), .uncond_br(uncond_br), .br_taken(br_taken),
    .pc(pc), .next_pc(next_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask
  task automatic step(input logic rst, input logic en, input logic [18:0] c,
                      input logic [25:0] b, input logic u, input logic t,
                      input logic lit = 0, input logic [63:0] lpc = 0,
                      input logic [63:0] lnx = 0);
    logic signed [63:0] off;
    logic [63:0] exp_nx;
    exp_t e;
    @(negedge clk);
    rst_n = rst; pc_en = en; cond_addr19 = c; br_addr26 = b; uncond_br = u; br_taken = t;
    if (!rst) m_pc = 64'h0;
    off = u ? 64'($signed(b)) : 64'($signed(c));
    exp_nx = t ? m_pc + off * 4 : m_pc + 4;
    e.pc = lit ? lpc : m_pc;
    e.nx = lit ? lnx : exp_nx;
    q.push_back(e);
    @(posedge clk);
    if (rst && en) m_pc = exp_nx;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("next_pc", next_pc, e.nx);
      end
    end
  end
  initial begin
    step(0, 1, 0, 0, 0, 0, 1, 64'h0, 64'h4);
    for (int i = 0; i < 16; i++)
      step(1, 1, 19'($urandom), 26'($urandom), 1, 0, 1, 64'(4 * i), 64'(4 * i + 4));
    step(1, 0, 0, 0, 1, 0, 1, 64'h40, 64'h44);
    step(0, 1, 0, 0, 0, 0, 1, 64'h0, 64'h4);
    step(1, 1, 0, 26'd2, 1, 1, 1, 64'h0, 64'h8);
    step(1, 1, 19'd30, 0, 0, 1, 1, 64'h8, 64'h80);
    step(1, 0, 19'h7FFFF, 0, 0, 1, 1, 64'h80, 64'h7C);
    step(0, 1, 0, 0, 0, 0, 1, 64'h0, 64'h4);
    step(1, 1, 0, 26'h3FFFFFF, 1, 1, 1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 1, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 19'd5, 0, 0, 1, 1, 64'h0, 64'h14);
    step(1, 1, 19'd5, 0, 0, 1, 1, 64'h0, 64'h14);
    step(1, 0, 0, 0, 0, 0, 1, 64'h14, 64'h18);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
           19'($urandom), 26'($urandom), 1'($urandom), 1'($urandom));
    repeat (2) @(negedge clk);
    #5;
    chk("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
